ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It consumes the ALU operands after the forwarding muxes and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While it works it raises a stall request that freezes IF/ID/EX and bubbles EX/MEM. The one-cycle result is then muxed onto the EX result bus ahead of the EX/MEM register.

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv_sign_fix.sv | 67 ++++++
 rtl/ex_muldiv.sv | 178 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide unit: operation and FSM
// encodings, datapath width, and small decode helpers.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div(funct3_e f);
    return f[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side port bundle of ex_muldiv. The pipeline (master) offers an
// M-extension op with i_valid; the unit (slave) stalls it through o_busy and
// pulses o_done for one cycle with o_result.
interface ex_muldiv_if;
  import muldiv_pkg::*;

  // Handshake: an op is taken when i_valid=1 and i_flush=0 while the unit is
  // idle; o_busy stalls the pipeline until o_done, which lasts one cycle.
  logic            i_valid;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            i_flush;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_funct3, i_op1, i_op2, i_flush,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_valid, i_funct3, i_op1, i_op2, i_flush,
    output o_busy, o_done, o_result
  );

endinterface

// File: rtl/ex_muldiv_sign_fix.sv
// Combinational sign handling around the unsigned iterative core: operand
// absolute values on entry, negation and result selection on exit.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  funct3_e           pre_funct3_i,
  input  logic [XLEN-1:0]   pre_op1_i,
  input  logic [XLEN-1:0]   pre_op2_i,
  output logic [XLEN-1:0]   pre_abs1_o,
  output logic [XLEN-1:0]   pre_abs2_o,
  output logic              pre_neg1_o,
  output logic              pre_neg2_o,

  input  funct3_e           post_funct3_i,
  input  logic              post_neg1_i,
  input  logic              post_neg2_i,
  input  logic              post_div0_i,
  input  logic [XLEN-1:0]   post_op1_i,
  input  logic [2*XLEN-1:0] post_raw_i,
  output logic [XLEN-1:0]   post_result_o
);

  logic              sgn1;
  logic              sgn2;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (pre_funct3_i)
      MUL, MULH, DIV, REM: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      MULHSU:  sgn1 = 1'b1;
      default: ;
    endcase
    pre_neg1_o = sgn1 & pre_op1_i[XLEN-1];
    pre_neg2_o = sgn2 & pre_op2_i[XLEN-1];
    pre_abs1_o = pre_neg1_o ? -pre_op1_i : pre_op1_i;
    pre_abs2_o = pre_neg2_o ? -pre_op2_i : pre_op2_i;
  end

  // Raw word is the product for multiplies and {remainder, quotient} for divides.
  always_comb begin
    prod_fix = (post_neg1_i ^ post_neg2_i) ? -post_raw_i : post_raw_i;
    quo      = post_raw_i[XLEN-1:0];
    rem      = post_raw_i[2*XLEN-1:XLEN];
    case (post_funct3_i)
      MUL:                 post_result_o = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: post_result_o = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU: begin
        if (post_div0_i)                    post_result_o = '1;
        else if (post_neg1_i ^ post_neg2_i) post_result_o = -quo;
        else                                post_result_o = quo;
      end
      default: begin
        if (post_div0_i)      post_result_o = post_op1_i;
        else if (post_neg1_i) post_result_o = -rem;
        else                  post_result_o = rem;
      end
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage (shift-add multiply,
// restoring divide). Define EX_MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  ex_muldiv_if.slave mif,
  output state_e     o_state
);

  state_e            state_q;
  funct3_e           f3_q;
  logic              neg1_q;
  logic              neg2_q;
  logic              div0_q;
  logic              done_q;
  logic [XLEN-1:0]   op1_q;
  logic [XLEN-1:0]   m_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [CNT_W-1:0]  cnt_q;

  funct3_e           f3_in;
  logic              accept;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic              neg1;
  logic              neg2;

  funct3_e           fix_f3;
  logic              fix_neg1;
  logic              fix_neg2;
  logic              fix_div0;
  logic [XLEN-1:0]   fix_op1;
  logic [2*XLEN-1:0] fix_raw;
  logic [XLEN-1:0]   fix_result;

  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;

  assign f3_in  = funct3_e'(mif.i_funct3);
  assign accept = (state_q == IDLE) && mif.i_valid && !mif.i_flush;

  assign mif.o_busy   = !mif.i_flush && ((state_q == IDLE && mif.i_valid) || state_q == CALC);
  assign mif.o_done   = done_q;
  assign mif.o_result = result_q;
  assign o_state      = state_q;

  muldiv_sign_fix u_sign_fix (
    .pre_funct3_i  (f3_in),
    .pre_op1_i     (mif.i_op1),
    .pre_op2_i     (mif.i_op2),
    .pre_abs1_o    (abs1),
    .pre_abs2_o    (abs2),
    .pre_neg1_o    (neg1),
    .pre_neg2_o    (neg2),
    .post_funct3_i (fix_f3),
    .post_neg1_i   (fix_neg1),
    .post_neg2_i   (fix_neg2),
    .post_div0_i   (fix_div0),
    .post_op1_i    (fix_op1),
    .post_raw_i    (fix_raw),
    .post_result_o (fix_result)
  );

  // Multiply: acc = {partial, multiplier}; m_q is the multiplicand.
  // Divide:   acc = {remainder, dividend/quotient}; m_q is the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, m_q};
    acc_d    = {mul_sum, acc_q[XLEN-1:1]};
    if (is_div(f3_q)) begin
      if (div_diff[XLEN+1]) acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      else                  acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

`ifdef EX_MULDIV_FAST_MUL_EN
  // A fast multiply completes on its accept edge, so the fix-up stage is fed
  // straight from the incoming operands while idle.
  always_comb begin
    if (state_q == IDLE) begin
      fix_f3   = f3_in;
      fix_neg1 = neg1;
      fix_neg2 = neg2;
      fix_div0 = 1'b0;
      fix_op1  = mif.i_op1;
      fix_raw  = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
    end else begin
      fix_f3   = f3_q;
      fix_neg1 = neg1_q;
      fix_neg2 = neg2_q;
      fix_div0 = div0_q;
      fix_op1  = op1_q;
      fix_raw  = acc_d;
    end
  end
`else
  assign fix_f3   = f3_q;
  assign fix_neg1 = neg1_q;
  assign fix_neg2 = neg2_q;
  assign fix_div0 = div0_q;
  assign fix_op1  = op1_q;
  assign fix_raw  = acc_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      f3_q     <= MUL;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      op1_q    <= '0;
      m_q      <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (mif.i_flush) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            f3_q   <= f3_in;
            neg1_q <= neg1;
            neg2_q <= neg2;
            div0_q <= (mif.i_op2 == '0);
            op1_q  <= mif.i_op1;
            cnt_q  <= CNT_W'(XLEN - 1);
            if (is_div(f3_in)) begin
              m_q   <= abs2;
              acc_q <= {{XLEN{1'b0}}, abs1};
            end else begin
              m_q   <= abs1;
              acc_q <= {{XLEN{1'b0}}, abs2};
            end
`ifdef EX_MULDIV_FAST_MUL_EN
            if (!is_div(f3_in)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= fix_result;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= fix_result;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a driver issues ops and queues expected
// results; a negedge monitor checks result, completion cycle and stall length.
module tb_ex_muldiv;
  import muldiv_pkg::*;

`ifdef EX_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  logic [31:0] last_exp = '0;

  logic [31:0] exp_q[$];
  int          start_q[$];
  int          lat_q[$];

  ex_muldiv_if mif();

  ex_muldiv dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .mif     (mif.slave),
    .o_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: one op per call; waits (bounded) for its completion.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int  lat;
    bit  got;
    lat = (FAST && !f3[2]) ? 1 : 33;
    @(posedge clk); #1;
    mif.i_valid  = 1'b1;
    mif.i_funct3 = f3;
    mif.i_op1    = a;
    mif.i_op2    = b;
    exp_q.push_back(exp);
    start_q.push_back(cyc);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    mif.i_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (mif.o_done) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    last_exp = exp;
  endtask

  // Monitor / scoreboard
  initial begin
    int          busy_cnt;
    logic [31:0] e;
    int          s;
    int          l;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || mif.i_flush) begin
        busy_cnt = 0;
      end else begin
        if (mif.o_busy) busy_cnt++;
        if (mif.o_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            s = start_q.pop_front();
            l = lat_q.pop_front();
            check("result", mif.o_result, e);
            check("done_cycle", 32'(cyc - s), 32'(l));
            check("busy_cycles", 32'(busy_cnt), 32'(l));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int s;
    bit saw_done;
    mif.i_valid  = 1'b0;
    mif.i_funct3 = 3'b000;
    mif.i_op1    = '0;
    mif.i_op2    = '0;
    mif.i_flush  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_done", {31'd0, mif.o_done}, 32'd0);
    check("rst_busy", {31'd0, mif.o_busy}, 32'd0);
    check("rst_result", mif.o_result, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op(3'b101, 32'd100,       32'd7,         32'd14);
    run_op(3'b111, 32'd100,       32'd7,         32'd2);
    run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op(3'b110, 32'd5,         32'd0,         32'd5);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Flush a DIV in its cycle 10
    @(posedge clk); #1;
    s = cyc;
    mif.i_valid  = 1'b1;
    mif.i_funct3 = 3'b100;
    mif.i_op1    = 32'd1000;
    mif.i_op2    = 32'd3;
    @(posedge clk); #1;
    mif.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    mif.i_flush = 1'b1;
    @(negedge clk);
    check("flush_cycle", 32'(cyc - s), 32'd10);
    check("flush_busy_drop", {31'd0, mif.o_busy}, 32'd0);
    @(posedge clk); #1;
    mif.i_flush = 1'b0;
    @(negedge clk);
    check("flush_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("flush_done", {31'd0, mif.o_done}, 32'd0);
    check("flush_result_held", mif.o_result, last_exp);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mif.o_done) saw_done = 1'b1;
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);

    // Reset in cycle 20 of a DIV
    @(posedge clk); #1;
    mif.i_valid  = 1'b1;
    mif.i_funct3 = 3'b100;
    mif.i_op1    = 32'd77;
    mif.i_op2    = 32'd5;
    @(posedge clk); #1;
    mif.i_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_rst_state", {30'd0, dbg_state}, {30'd0, CALC});
    rst = 1'b1;
    #1;
    check("midrst_done", {31'd0, mif.o_done}, 32'd0);
    check("midrst_busy", {31'd0, mif.o_busy}, 32'd0);
    check("midrst_result", mif.o_result, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    run_op(3'b100, 32'd100,       32'd7,         32'd14);
    run_op(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
